// File: rtl/k_alu_if.sv
// Operand/result bundle for k_alu: the master side drives operands, the
// slave (ALU) side returns the registered result and status flags.
interface k_alu_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic [3:0]       op;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] result;
   logic             out_valid;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             illegal;

   modport master (
      output in_valid, op, opA, opB,
      input  result, out_valid, zero, negative, carry, overflow, illegal
   );

   modport slave (
      input  in_valid, op, opA, opB,
      output result, out_valid, zero, negative, carry, overflow, illegal
   );
endinterface

// File: rtl/k_alu.sv
// Registered single-cycle integer ALU for the K_DSP datapath.
// Define K_ALU_MUL_EN to build the MUL/MULHU multiplier; otherwise D/E are reserved.
module k_alu #(
   parameter int WIDTH = 32
) (
   input logic    clk,
   input logic    rst,
   k_alu_if.slave io_alu
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH:0]          w_sum;
   logic [WIDTH:0]          w_diff;
   logic [SHW-1:0]          w_shamt;
   logic signed [WIDTH-1:0] w_a_s;
   logic signed [WIDTH-1:0] w_b_s;
   logic [WIDTH-1:0]        w_result;
   logic                    w_carry;
   logic                    w_ovf;
   logic                    w_illegal;

   logic [WIDTH-1:0]        r_result;
   logic                    r_out_valid;
   logic                    r_zero;
   logic                    r_negative;
   logic                    r_carry;
   logic                    r_overflow;
   logic                    r_illegal;

   assign w_sum   = {1'b0, io_alu.opA} + {1'b0, io_alu.opB};
   // Subtract as A + ~B + 1 so bit WIDTH is the inverted borrow.
   assign w_diff  = {1'b0, io_alu.opA} + {1'b0, ~io_alu.opB} + (WIDTH+1)'(1);
   assign w_shamt = io_alu.opB[SHW-1:0];
   assign w_a_s   = io_alu.opA;
   assign w_b_s   = io_alu.opB;

`ifdef K_ALU_MUL_EN
   logic [2*WIDTH-1:0] w_prod;
   assign w_prod = {{WIDTH{1'b0}}, io_alu.opA} * {{WIDTH{1'b0}}, io_alu.opB};
`endif

   always_comb begin
      w_result  = '0;
      w_carry   = 1'b0;
      w_ovf     = 1'b0;
      w_illegal = 1'b0;
      case (io_alu.op)
         4'h0: begin
            w_result = w_sum[WIDTH-1:0];
            w_carry  = w_sum[WIDTH];
            w_ovf    = (io_alu.opA[WIDTH-1] == io_alu.opB[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != io_alu.opA[WIDTH-1]);
         end
         4'h1: begin
            w_result = w_diff[WIDTH-1:0];
            w_carry  = ~w_diff[WIDTH];
            w_ovf    = (io_alu.opA[WIDTH-1] != io_alu.opB[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != io_alu.opA[WIDTH-1]);
         end
         4'h2: w_result = io_alu.opA & io_alu.opB;
         4'h3: w_result = io_alu.opA | io_alu.opB;
         4'h4: w_result = io_alu.opA ^ io_alu.opB;
         4'h5: w_result = ~(io_alu.opA | io_alu.opB);
         4'h6: w_result = io_alu.opA << w_shamt;
         4'h7: w_result = io_alu.opA >> w_shamt;
         4'h8: w_result = $unsigned(w_a_s >>> w_shamt);
         4'h9: w_result = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
         4'hA: w_result = {{(WIDTH-1){1'b0}}, (io_alu.opA < io_alu.opB)};
         4'hB: w_result = io_alu.opA;
         4'hC: w_result = io_alu.opB;
`ifdef K_ALU_MUL_EN
         4'hD: w_result = w_prod[WIDTH-1:0];
         4'hE: w_result = w_prod[2*WIDTH-1:WIDTH];
`endif
         default: w_illegal = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_result    <= '0;
         r_out_valid <= 1'b0;
         r_zero      <= 1'b0;
         r_negative  <= 1'b0;
         r_carry     <= 1'b0;
         r_overflow  <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_out_valid <= io_alu.in_valid;
         if (io_alu.in_valid) begin
            r_result   <= w_result;
            r_zero     <= (w_result == '0);
            r_negative <= w_result[WIDTH-1];
            r_carry    <= w_carry;
            r_overflow <= w_ovf;
            r_illegal  <= w_illegal;
         end
      end
   end

   assign io_alu.result    = r_result;
   assign io_alu.out_valid = r_out_valid;
   assign io_alu.zero      = r_zero;
   assign io_alu.negative  = r_negative;
   assign io_alu.carry     = r_carry;
   assign io_alu.overflow  = r_overflow;
   assign io_alu.illegal   = r_illegal;

endmodule

// File: tb/tb_k_alu.sv
// Directed-vector bench for k_alu; expected values are hand-computed.
// Follows K_ALU_MUL_EN to pick the multiply expectations.
module tb_k_alu;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        c;
      logic        v;
      logic        ill;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   k_alu_if #(.WIDTH(32)) alu_if ();

   k_alu #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_alu (alu_if)
   );

   task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic c, input logic v, input logic ill);
      vec_t t;
      t.op = op; t.a = a; t.b = b; t.res = res; t.c = c; t.v = v; t.ill = ill;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   // flags packed as {out_valid, zero, negative, carry, overflow, illegal}
   function automatic logic [31:0] flags_now();
      return {26'd0, alu_if.out_valid, alu_if.zero, alu_if.negative,
              alu_if.carry, alu_if.overflow, alu_if.illegal};
   endfunction

   function automatic logic [31:0] flags_exp(input logic vld, input logic [31:0] res,
                                             input logic c, input logic v, input logic ill);
      return {26'd0, vld, (res == 32'd0), res[31], c, v, ill};
   endfunction

   initial begin
      add_vec(4'h0, 32'd10,        32'd20,        32'd30,        0, 0, 0);
      add_vec(4'h0, 32'd15,        32'd30,        32'd45,        0, 0, 0);
      add_vec(4'h0, 32'hFFFFFFFF,  32'd1,         32'h00000000,  1, 0, 0);
      add_vec(4'h0, 32'h7FFFFFFF,  32'd1,         32'h80000000,  0, 1, 0);
      add_vec(4'h1, 32'd5,         32'd7,         32'hFFFFFFFE,  1, 0, 0);
      add_vec(4'h1, 32'd7,         32'd5,         32'd2,         0, 0, 0);
      add_vec(4'h1, 32'h80000000,  32'd1,         32'h7FFFFFFF,  0, 1, 0);
      add_vec(4'h2, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  0, 0, 0);
      add_vec(4'h3, 32'h0F0F0000,  32'h000000F0,  32'h0F0F00F0,  0, 0, 0);
      add_vec(4'h4, 32'hFFFF0000,  32'h0F0F0F0F,  32'hF0F00F0F,  0, 0, 0);
      add_vec(4'h5, 32'h00000000,  32'h00000000,  32'hFFFFFFFF,  0, 0, 0);
      add_vec(4'h5, 32'hFFFFFFFF,  32'h00000000,  32'h00000000,  0, 0, 0);
      add_vec(4'h6, 32'd1,         32'd31,        32'h80000000,  0, 0, 0);
      add_vec(4'h6, 32'h12345678,  32'h00000020,  32'h12345678,  0, 0, 0);
      add_vec(4'h7, 32'h80000000,  32'd4,         32'h08000000,  0, 0, 0);
      add_vec(4'h8, 32'h80000000,  32'd4,         32'hF8000000,  0, 0, 0);
      add_vec(4'h8, 32'h12345678,  32'd0,         32'h12345678,  0, 0, 0);
      add_vec(4'h9, 32'hFFFFFFFF,  32'd1,         32'd1,         0, 0, 0);
      add_vec(4'hA, 32'hFFFFFFFF,  32'd1,         32'd0,         0, 0, 0);
      add_vec(4'hA, 32'd1,         32'hFFFFFFFF,  32'd1,         0, 0, 0);
      add_vec(4'hB, 32'hDEADBEEF,  32'h01234567,  32'hDEADBEEF,  0, 0, 0);
      add_vec(4'hC, 32'hDEADBEEF,  32'h01234567,  32'h01234567,  0, 0, 0);
`ifdef K_ALU_MUL_EN
      add_vec(4'hD, 32'h00010000,  32'h00010000,  32'h00000000,  0, 0, 0);
      add_vec(4'hE, 32'h00010000,  32'h00010000,  32'h00000001,  0, 0, 0);
      add_vec(4'hD, 32'd3,         32'd5,         32'd15,        0, 0, 0);
      add_vec(4'hE, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  0, 0, 0);
`else
      add_vec(4'hD, 32'h00010000,  32'h00010000,  32'h00000000,  0, 0, 1);
      add_vec(4'hE, 32'h00010000,  32'h00010000,  32'h00000000,  0, 0, 1);
      add_vec(4'hD, 32'd3,         32'd5,         32'h00000000,  0, 0, 1);
`endif
      add_vec(4'hF, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  0, 0, 1);

      // Reset held two cycles with a live transaction presented.
      rst = 1'b1;
      alu_if.in_valid = 1'b1;
      alu_if.op  = 4'h0;
      alu_if.opA = 32'd1;
      alu_if.opB = 32'd2;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", alu_if.result, 32'd0);
      check("reset_flags",  flags_now(), 32'd0);

      @(negedge clk);
      rst = 1'b0;
      alu_if.in_valid = 1'b0;
      @(posedge clk); #1;
      check("idle_result", alu_if.result, 32'd0);
      check("idle_flags",  flags_now(), 32'd0);

      // Back-to-back vectors, one per cycle.
      foreach (vecs[i]) begin
         @(negedge clk);
         alu_if.in_valid = 1'b1;
         alu_if.op  = vecs[i].op;
         alu_if.opA = vecs[i].a;
         alu_if.opB = vecs[i].b;
         @(posedge clk); #1;
         check($sformatf("vec%0d_op%0h_result", i, vecs[i].op), alu_if.result, vecs[i].res);
         check($sformatf("vec%0d_op%0h_flags", i, vecs[i].op), flags_now(),
               flags_exp(1'b1, vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].ill));
      end

      // Produce a SUB with borrow, then idle: value and flags must hold.
      @(negedge clk);
      alu_if.in_valid = 1'b1;
      alu_if.op  = 4'h1;
      alu_if.opA = 32'd5;
      alu_if.opB = 32'd7;
      @(negedge clk);
      alu_if.in_valid = 1'b0;
      alu_if.op  = 4'h0;
      alu_if.opA = 32'd1;
      alu_if.opB = 32'd1;
      repeat (2) @(posedge clk);
      #1;
      check("hold_result", alu_if.result, 32'hFFFFFFFE);
      check("hold_flags",  flags_now(), flags_exp(1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0));

      // Reset asserted together with a valid transaction drops it.
      @(negedge clk);
      alu_if.in_valid = 1'b1;
      alu_if.op  = 4'h0;
      alu_if.opA = 32'h7FFFFFFF;
      alu_if.opB = 32'd1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_result", alu_if.result, 32'd0);
      check("midrst_flags",  flags_now(), 32'd0);

      // First transaction after reset release lands one cycle later.
      @(negedge clk);
      rst = 1'b0;
      alu_if.op  = 4'h0;
      alu_if.opA = 32'd100;
      alu_if.opB = 32'd23;
      @(posedge clk); #1;
      check("post_rst_result", alu_if.result, 32'd123);
      check("post_rst_flags",  flags_now(), flags_exp(1'b1, 32'd123, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      alu_if.in_valid = 1'b0;
      @(posedge clk); #1;
      check("post_rst_idle_valid", {31'd0, alu_if.out_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
